systolic_deskew_out: RTL and testbench

- Output-side counterpart of the systolic input-setup stage. It sits directly downstream of the MAC array's bottom edge.
- Column j of the array emits row r results j cycles after column 0. This block re-aligns those staggered column results into whole row vectors.
- Aligned rows are buffered in a row FIFO and handed to the result memory / accumulator over a valid/ready handshake.
- It counts rows per tile, flags skew and overflow faults, and asks the array to hold when buffer space runs low.

---
 rtl/systolic_deskew_out.sv | 223 ++++++++++++++++++++++
 tb/tb_systolic_deskew_out.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_deskew_out.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : systolic_deskew_out                                          |
// | Description : Re-aligns staggered MAC-array column results into row        |
// |               vectors, buffers them in a FWFT row FIFO with valid/ready.   |
// |               Optional macro DESKEW_ROW_TAG_EN adds out_row_idx.           |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module systolic_deskew_out #(
    parameter int DATA_WIDTH = 32,
    parameter int MAC_WIDTH  = 16,
    parameter int FIFO_DEPTH = 32,
    parameter int ROWS_W     = 16
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic [ROWS_W-1:0]                tile_rows,
    input  logic [MAC_WIDTH-1:0]             col_valid,
    input  logic [DATA_WIDTH*MAC_WIDTH-1:0]  col_data,
    output logic                             array_hold,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH*MAC_WIDTH-1:0]  out_row,
`ifdef DESKEW_ROW_TAG_EN
    output logic [ROWS_W-1:0]                out_row_idx,
`endif
    output logic                             busy,
    output logic                             tile_done,
    output logic                             overflow_err,
    output logic                             skew_err
);

    localparam int c_ROW_W = DATA_WIDTH * MAC_WIDTH;
    localparam int c_AW    = $clog2(FIFO_DEPTH);
    localparam int c_CW    = c_AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [ROWS_W-1:0]    r_tile_rows;
    logic [ROWS_W-1:0]    r_rows_in;
    logic                 r_ovf;
    logic                 r_skew;
    logic                 r_done;

    logic [c_AW-1:0]      r_wr;
    logic [c_AW-1:0]      r_rd;
    logic [c_CW-1:0]      r_count;
    logic                 r_out_valid;
    logic [c_ROW_W-1:0]   r_out_row;
    logic                 r_hold;
    logic [c_ROW_W-1:0]   r_mem [FIFO_DEPTH];
`ifdef DESKEW_ROW_TAG_EN
    logic [ROWS_W-1:0]    r_tag_mem [FIFO_DEPTH];
    logic [ROWS_W-1:0]    r_out_tag;
`endif

    logic [MAC_WIDTH-1:0] w_al_valid;
    logic [c_ROW_W-1:0]   w_al_data;
    logic                 w_align_any;
    logic                 w_align_all;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push_req;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_head_bypass;
    logic [c_AW-1:0]      w_rd_nxt;
    logic [c_CW-1:0]      w_count_nxt;

    // Column j gets MAC_WIDTH-1-j stages so every column of a row lines up with the last one.
    for (genvar j = 0; j < MAC_WIDTH; j++) begin : g_col
        localparam int c_STAGES = MAC_WIDTH - 1 - j;
        if (c_STAGES == 0) begin : g_pass
            assign w_al_valid[j]                         = col_valid[j];
            assign w_al_data[j*DATA_WIDTH +: DATA_WIDTH] = col_data[j*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_dly
            logic [c_STAGES-1:0]   r_dly_v;
            logic [DATA_WIDTH-1:0] r_dly_d [c_STAGES];
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_dly_v <= '0;
                    for (int k = 0; k < c_STAGES; k++) begin
                        r_dly_d[k] <= '0;
                    end
                end else begin
                    r_dly_v[0] <= col_valid[j];
                    r_dly_d[0] <= col_data[j*DATA_WIDTH +: DATA_WIDTH];
                    for (int k = 1; k < c_STAGES; k++) begin
                        r_dly_v[k] <= r_dly_v[k-1];
                        r_dly_d[k] <= r_dly_d[k-1];
                    end
                end
            end
            assign w_al_valid[j]                         = r_dly_v[c_STAGES-1];
            assign w_al_data[j*DATA_WIDTH +: DATA_WIDTH] = r_dly_d[c_STAGES-1];
        end
    end

    assign w_align_any   = |w_al_valid;
    assign w_align_all   = &w_al_valid;
    assign w_full        = (r_count == c_CW'(FIFO_DEPTH));
    assign w_pop         = r_out_valid && out_ready;
    assign w_push_req    = (r_state == S_RUN) && w_align_all;
    assign w_push        = w_push_req && (!w_full || w_pop);
    assign w_drop        = w_push_req && w_full && !w_pop;
    assign w_rd_nxt      = r_rd + c_AW'(w_pop);
    assign w_count_nxt   = r_count + c_CW'(w_push) - c_CW'(w_pop);
    // The incoming row becomes the head directly when nothing else remains ahead of it.
    assign w_head_bypass = w_push && ((r_count == '0) || ((r_count == c_CW'(1)) && w_pop));

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr] <= w_al_data;
`ifdef DESKEW_ROW_TAG_EN
            r_tag_mem[r_wr] <= r_rows_in;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr        <= '0;
            r_rd        <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_row   <= '0;
            r_hold      <= 1'b0;
`ifdef DESKEW_ROW_TAG_EN
            r_out_tag   <= '0;
`endif
        end else begin
            r_wr        <= r_wr + c_AW'(w_push);
            r_rd        <= w_rd_nxt;
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != '0);
            // Threshold leaves room for rows still travelling through the skew lines.
            r_hold      <= (r_count >= c_CW'(FIFO_DEPTH - MAC_WIDTH));
            if (w_count_nxt != '0) begin
                if (w_head_bypass) begin
                    r_out_row <= w_al_data;
`ifdef DESKEW_ROW_TAG_EN
                    r_out_tag <= r_rows_in;
`endif
                end else begin
                    r_out_row <= r_mem[w_rd_nxt];
`ifdef DESKEW_ROW_TAG_EN
                    r_out_tag <= r_tag_mem[w_rd_nxt];
`endif
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_tile_rows <= '0;
            r_rows_in   <= '0;
            r_ovf       <= 1'b0;
            r_skew      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_tile_rows <= tile_rows;
                        r_rows_in   <= '0;
                        r_ovf       <= 1'b0;
                        r_skew      <= 1'b0;
                        r_state     <= (tile_rows == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_align_all) begin
                        r_rows_in <= r_rows_in + ROWS_W'(1);
                        if (w_drop) begin
                            r_ovf <= 1'b1;
                        end
                        if (r_rows_in + ROWS_W'(1) == r_tile_rows) begin
                            r_state <= S_DRAIN;
                        end
                    end else if (w_align_any) begin
                        r_skew <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_align_any) begin
                        r_skew <= 1'b1;
                    end
                    if (r_count == '0) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign array_hold   = r_hold;
    assign out_valid    = r_out_valid;
    assign out_row      = r_out_row;
    assign busy         = (r_state != S_IDLE);
    assign tile_done    = r_done;
    assign overflow_err = r_ovf;
    assign skew_err     = r_skew;
`ifdef DESKEW_ROW_TAG_EN
    assign out_row_idx  = r_out_tag;
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_deskew_out.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_systolic_deskew_out                                       |
// | Description : Self-checking bench: scenario table, timing sequences and    |
// |               randomized tiles against an in-order row reference model.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_systolic_deskew_out;

    localparam int DW   = 32;
    localparam int N    = 16;
    localparam int D    = 32;
    localparam int RW   = 16;
    localparam int ROWW = DW * N;
    localparam int SCH  = 1024;

    logic            clock;
    logic            reset;
    logic            start;
    logic [RW-1:0]   tile_rows;
    logic [N-1:0]    col_valid;
    logic [ROWW-1:0] col_data;
    logic            array_hold;
    logic            out_valid;
    logic            out_ready;
    logic [ROWW-1:0] out_row;
    logic            busy;
    logic            tile_done;
    logic            overflow_err;
    logic            skew_err;
`ifdef DESKEW_ROW_TAG_EN
    logic [RW-1:0]   out_row_idx;
`endif

    systolic_deskew_out #(
        .DATA_WIDTH (DW),
        .MAC_WIDTH  (N),
        .FIFO_DEPTH (D),
        .ROWS_W     (RW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .tile_rows    (tile_rows),
        .col_valid    (col_valid),
        .col_data     (col_data),
        .array_hold   (array_hold),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_row      (out_row),
`ifdef DESKEW_ROW_TAG_EN
        .out_row_idx  (out_row_idx),
`endif
        .busy         (busy),
        .tile_done    (tile_done),
        .overflow_err (overflow_err),
        .skew_err     (skew_err)
    );

    typedef struct {
        int tr;
        int nr;
        int gap;
        int mode;
        int late_row;
        int late_col;
        int exp_rows;
        bit exp_skew;
        bit exp_ovf;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;
    int cyc = 0;
    int rmode = 0;

    logic [N-1:0]    sch_v [SCH];
    logic [ROWW-1:0] sch_d [SCH];
    logic [ROWW-1:0] got_q [$];
    logic [ROWW-1:0] exp_q [$];
    int              got_i [$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [ROWW-1:0] act, input logic [ROWW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    function automatic logic [ROWW-1:0] mk_row(input int r);
        logic [ROWW-1:0] row;
        for (int j = 0; j < N; j++) row[j*DW +: DW] = DW'(r * 100 + j);
        return row;
    endfunction

    function automatic logic [ROWW-1:0] rand_row();
        logic [ROWW-1:0] row;
        for (int j = 0; j < N; j++) row[j*DW +: DW] = $urandom;
        return row;
    endfunction

    // Column j of a row driven at cycle t+j (one extra cycle for late_col).
    task automatic sched_row(input int t, input logic [ROWW-1:0] row, input int late_col);
        int tt;
        for (int j = 0; j < N; j++) begin
            tt = (t + j + ((j == late_col) ? 1 : 0)) % SCH;
            sch_v[tt][j]            = 1'b1;
            sch_d[tt][j*DW +: DW]   = row[j*DW +: DW];
        end
    endtask

    // Input driver and pop monitor, all on the falling edge.
    initial begin
        int idx;
        bit hold_chk;
        logic [ROWW-1:0] prev_row;
        for (int i = 0; i < SCH; i++) begin
            sch_v[i] = '0;
            sch_d[i] = '0;
        end
        hold_chk = 1'b0;
        prev_row = '0;
        forever begin
            @(negedge clock);
            idx       = cyc % SCH;
            col_valid = sch_v[idx];
            col_data  = sch_d[idx];
            sch_v[idx] = '0;
            sch_d[idx] = '0;
            cyc++;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (!reset) begin
                hold_chk = 1'b0;
            end else begin
                if (hold_chk) chk("row_stable", out_row, prev_row);
                if (out_valid && out_ready) begin
                    got_q.push_back(out_row);
`ifdef DESKEW_ROW_TAG_EN
                    got_i.push_back(int'(out_row_idx));
`endif
                end
                if (tile_done) n_done++;
                hold_chk = out_valid && !out_ready;
                prev_row = out_row;
            end
        end
    end

    task automatic clear_lists();
        got_q.delete();
        got_i.delete();
        exp_q.delete();
    endtask

    task automatic cmp_lists(input string nm);
        int n;
        chk_int({nm, "_row_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            chk({nm, "_row_data"}, got_q[k], exp_q[k]);
`ifdef DESKEW_ROW_TAG_EN
            chk_int({nm, "_row_idx"}, got_i[k], k);
`endif
        end
    endtask

    task automatic wait_done(input string nm, input int budget);
        int k;
        k = 0;
        while (!tile_done && k < budget) begin
            tick(1);
            k++;
        end
        chk_int({nm, "_tile_done"}, int'(tile_done), 1);
        chk_int({nm, "_busy_low"}, int'(busy), 0);
    endtask

    task automatic run_tile(input string nm, input vec_t v, input bit rnd);
        logic [ROWW-1:0] row;
        int kept;
        int d0;
        int g;
        clear_lists();
        d0 = n_done;
        kept = 0;
        rmode = v.mode;
        tile_rows = RW'(v.tr);
        start = 1'b1;
        for (int r = 0; r < v.nr; r++) begin
            if (rnd) begin
                for (int k = 0; k < 300 && array_hold; k++) tick(1);
                row = rand_row();
            end else begin
                row = mk_row(r);
            end
            sched_row(cyc, row, (r == v.late_row) ? v.late_col : -1);
            if (r != v.late_row) begin
                if (kept < v.exp_rows) exp_q.push_back(row);
                kept++;
            end
            g = rnd ? $urandom_range(1, 3) : v.gap;
            tick(1);
            start = 1'b0;
            if (g > 0) tick(g);
        end
        if (v.mode == 1) begin
            tick(N + 4);
            rmode = 0;
        end
        wait_done(nm, 500);
        tick(2);
        cmp_lists(nm);
        chk_int({nm, "_skew_err"}, int'(skew_err), int'(v.exp_skew));
        chk_int({nm, "_overflow_err"}, int'(overflow_err), int'(v.exp_ovf));
        chk_int({nm, "_done_once"}, n_done - d0, 1);
        rmode = 0;
        tick(3);
    endtask

    initial begin
        vec_t tbl[6];
        vec_t rv;
        int d0;
        tbl[0] = '{3,  3,  0, 0, -1, -1, 3,  1'b0, 1'b0};
        tbl[1] = '{2,  3,  3, 0,  1,  5, 2,  1'b1, 1'b0};
        tbl[2] = '{3,  4,  0, 0, -1, -1, 3,  1'b1, 1'b0};
        tbl[3] = '{10, 10, 1, 2, -1, -1, 10, 1'b0, 1'b0};
        tbl[4] = '{33, 33, 0, 1, -1, -1, 32, 1'b0, 1'b1};
        tbl[5] = '{20, 20, 0, 1, -1, -1, 20, 1'b0, 1'b0};

        reset = 1'b0;
        start = 1'b0;
        tile_rows = '0;
        col_valid = '0;
        col_data = '0;
        out_ready = 1'b0;
        tick(3);
        chk_int("rst_out_valid", int'(out_valid), 0);
        chk_int("rst_busy", int'(busy), 0);
        chk_int("rst_hold", int'(array_hold), 0);
        chk_int("rst_tile_done", int'(tile_done), 0);
        chk_int("rst_errors", int'({overflow_err, skew_err}), 0);
        chk("rst_out_row", out_row, '0);
        reset = 1'b1;
        tick(2);

        // Latency: first row visible 15 edges after its column-0 sample.
        clear_lists();
        rmode = 0;
        tile_rows = RW'(3);
        start = 1'b1;
        for (int r = 0; r < 3; r++) begin
            sched_row(cyc + r, mk_row(r), -1);
            exp_q.push_back(mk_row(r));
        end
        d0 = n_done;
        tick(1);
        start = 1'b0;
        tick(14);
        chk_int("lat_not_yet", int'(out_valid), 0);
        tick(1);
        chk_int("lat_valid", int'(out_valid), 1);
        chk("lat_row0", out_row, mk_row(0));
        wait_done("lat", 60);
        tick(1);
        chk_int("lat_done_pulse_end", int'(tile_done), 0);
        tick(2);
        cmp_lists("lat");
        chk_int("lat_done_once", n_done - d0, 1);
        tick(3);

        // Hold asserts one cycle after count reaches FIFO_DEPTH-N.
        clear_lists();
        rmode = 1;
        tile_rows = RW'(20);
        start = 1'b1;
        for (int r = 0; r < 20; r++) begin
            sched_row(cyc + r, mk_row(r), -1);
            exp_q.push_back(mk_row(r));
        end
        tick(1);
        start = 1'b0;
        tick(30);
        chk_int("hold_low_at_16", int'(array_hold), 0);
        tick(1);
        chk_int("hold_high", int'(array_hold), 1);
        chk("hold_head_row0", out_row, mk_row(0));
        tick(10);
        rmode = 0;
        wait_done("hold", 100);
        tick(2);
        cmp_lists("hold");
        tick(3);

        // Overflow on the 33rd push with the consumer stalled.
        clear_lists();
        rmode = 1;
        tile_rows = RW'(33);
        start = 1'b1;
        for (int r = 0; r < 33; r++) begin
            sched_row(cyc + r, mk_row(r), -1);
            if (r < D) exp_q.push_back(mk_row(r));
        end
        tick(1);
        start = 1'b0;
        tick(46);
        chk_int("ovf_before", int'(overflow_err), 0);
        tick(1);
        chk_int("ovf_at_33", int'(overflow_err), 1);
        tick(5);
        rmode = 0;
        wait_done("ovf", 100);
        tick(2);
        cmp_lists("ovf");
        chk_int("ovf_sticky", int'(overflow_err), 1);
        tick(3);

        for (int i = 0; i < 6; i++) run_tile($sformatf("tbl%0d", i), tbl[i], 1'b0);

        // Reset mid-tile with 4 rows buffered and a skew flag raised.
        clear_lists();
        rmode = 1;
        tile_rows = RW'(10);
        start = 1'b1;
        for (int r = 0; r < 4; r++) sched_row(cyc + r, mk_row(r), -1);
        sch_v[(cyc + 6) % SCH][0] = 1'b1;
        tick(1);
        start = 1'b0;
        tick(22);
        chk_int("mid_valid_before", int'(out_valid), 1);
        chk_int("mid_skew_before", int'(skew_err), 1);
        reset = 1'b0;
        #1;
        chk_int("mid_rst_valid", int'(out_valid), 0);
        chk_int("mid_rst_busy", int'(busy), 0);
        chk_int("mid_rst_hold", int'(array_hold), 0);
        chk_int("mid_rst_errors", int'({overflow_err, skew_err}), 0);
        chk("mid_rst_row", out_row, '0);
        tick(1);
        reset = 1'b1;
        rmode = 0;
        tick(2);
        clear_lists();
        tile_rows = RW'(1);
        start = 1'b1;
        sched_row(cyc, mk_row(7), -1);
        exp_q.push_back(mk_row(7));
        tick(1);
        start = 1'b0;
        wait_done("mid_after", 60);
        tick(2);
        cmp_lists("mid_after");
        tick(3);

        // Zero-row tile: done pulse on the second cycle after start.
        clear_lists();
        tile_rows = '0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk_int("zero_done_c1", int'(tile_done), 0);
        chk_int("zero_busy_c1", int'(busy), 1);
        tick(1);
        chk_int("zero_done_c2", int'(tile_done), 1);
        chk_int("zero_busy_c2", int'(busy), 0);
        tick(1);
        chk_int("zero_done_c3", int'(tile_done), 0);
        chk_int("zero_no_fifo", int'(out_valid), 0);
        tick(3);
        chk_int("zero_no_pops", got_q.size(), 0);

        for (int i = 0; i < 4; i++) begin
            rv.tr = $urandom_range(5, 24);
            rv.nr = rv.tr;
            rv.gap = 1;
            rv.mode = 2;
            rv.late_row = -1;
            rv.late_col = -1;
            rv.exp_rows = rv.tr;
            rv.exp_skew = 1'b0;
            rv.exp_ovf = 1'b0;
            run_tile($sformatf("rnd%0d", i), rv, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
